// File: rtl/mux_arb_pkg.sv
// Shared constants for the round-robin mux arbiter: output-stage states and requester indices.
package mux_arb_pkg;
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;
  localparam logic SRC_IN0  = 1'b0;
  localparam logic SRC_IN1  = 1'b1;
endpackage

// File: rtl/mux_data_8b.sv
// Shared 2:1 datapath mux; sel=0 passes in0, sel=1 passes in1.
module mux_data_8b #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic              sel,
  output logic [DATA_W-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/mux_arbiter_8b.sv
// Round-robin arbiter for two valid/ready requesters sharing mux_data_8b, with a one-entry output stage.
// Define MUX_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt0/grant_cnt1).
import mux_arb_pkg::*;

module mux_arbiter_8b #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  logic              state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_src_q, out_src_d;
  logic [DATA_W-1:0] mux_out;
  logic              winner, any_req, can_accept, accept;

  assign any_req    = in0_valid | in1_valid;
  assign can_accept = (state_q == ST_EMPTY) | out_ready;
  // With both requesting, the one that did not win last time gets the grant.
  assign winner     = (in0_valid & in1_valid) ? ~last_grant_q :
                      (in1_valid ? SRC_IN1 : SRC_IN0);
  assign sel        = any_req ? winner : SRC_IN0;
  assign in0_ready  = can_accept & in0_valid & (winner == SRC_IN0);
  assign in1_ready  = can_accept & in1_valid & (winner == SRC_IN1);
  assign accept     = in0_ready | in1_ready;

  mux_data_8b #(.DATA_W(DATA_W)) u_mux (
    .in0 (in0_data),
    .in1 (in1_data),
    .sel (sel),
    .out (mux_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= SRC_IN1;
      out_data_q   <= '0;
      out_src_q    <= SRC_IN0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
    endcase
  end

  // Priority only rotates on an actual transfer, so idle cycles keep fairness intact.
  always_comb begin
    last_grant_d = last_grant_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    if (accept) begin
      last_grant_d = winner;
      out_data_d   = mux_out;
      out_src_d    = winner;
    end
  end

  always_comb begin
    out_valid = (state_q == ST_FULL);
    out_data  = out_data_q;
    out_src   = out_src_q;
  end

`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (in0_ready && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
      if (in1_ready && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule
